// File: rtl/ram_io_responder.sv
// Memory-mapped responder: byte RAM, UART RX/TX ports, a free-running cycle counter
// with snapshot readout, and a program-stop flag, all behind a single CPU bus.
module ram_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH       = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_stop
);

  localparam logic [31:0] RAM_BYTES = 32'(1) << RAM_ADDR_WIDTH;
  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C   = (PTR_W + 1)'(TX_DEPTH);
  localparam logic [PTR_W:0] FULL_MARK = (PTR_W + 1)'(TX_DEPTH - 2);
  localparam logic [PTR_W:0] PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};

  logic [17:0] addr;
  logic [15:0] io_reg;
  logic        io_sel;
  logic        ram_sel;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;

  logic [7:0]  ram [0:(1 << RAM_ADDR_WIDTH) - 1];
  logic [7:0]  fifo_mem [TX_DEPTH];

  logic [31:0] cycle_cnt;
  logic [31:0] snapshot;
  logic [7:0]  rd_data;

  logic        rd_rx;
  logic        rd_cnt;
  logic        wr_tx;
  logic        wr_stop;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic [7:0]  push_byte;

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [PTR_W:0] tx_count;
  logic [PTR_W:0] next_count;
  logic           fifo_full;
  logic           tx_overflow;
  logic           unused_bits;

  assign addr    = mem_a[17:0];
  assign io_reg  = addr[15:0];
  assign io_sel  = (addr[17:16] == 2'b11);
  assign ram_sel = !io_sel && ({14'b0, addr} < RAM_BYTES);
  assign ram_idx = addr[RAM_ADDR_WIDTH-1:0];

  assign rd_rx   = !mem_wr && io_sel && (io_reg == 16'h0000);
  assign rd_cnt  = !mem_wr && io_sel && (io_reg == 16'h0004);
  assign wr_tx   = mem_wr && io_sel && (io_reg == 16'h0000) && (mem_dout != 8'h00);
  assign wr_stop = mem_wr && io_sel && (io_reg == 16'h0004);

  // RX consumption is combinational so the UART sees the pop in the access cycle.
  assign rx_pop  = !rst_in && rd_rx && rx_valid;

  assign unused_bits = ^{mem_a[31:18], tx_overflow};

  always_comb begin
    rd_data = 8'h00;
    if (io_sel) begin
      case (io_reg)
        16'h0000: rd_data = rx_valid ? rx_data : 8'h00;
        16'h0004: rd_data = cycle_cnt[7:0];
        16'h0005: rd_data = snapshot[15:8];
        16'h0006: rd_data = snapshot[23:16];
        16'h0007: rd_data = snapshot[31:24];
        default:  rd_data = 8'h00;
      endcase
    end else if (ram_sel) begin
      rd_data = ram[ram_idx];
    end
  end

  // RAM contents survive reset, so the array lives in its own unreset process.
  always_ff @(posedge clk_in) begin
    if (mem_wr && ram_sel)
      ram[ram_idx] <= mem_dout;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din      <= 8'h00;
      cycle_cnt    <= 32'h0;
      snapshot     <= 32'h0;
      program_stop <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;
      if (!mem_wr)
        mem_din <= rd_data;
      if (rd_cnt)
        snapshot <= cycle_cnt;
      if (wr_stop)
        program_stop <= 1'b1;
    end
  end

  assign tx_count  = wr_ptr - rd_ptr;
  assign tx_valid  = (tx_count != '0);
  assign fifo_full = (tx_count == DEPTH_C);
  assign tx_data   = tx_valid ? fifo_mem[rd_ptr[PTR_W-1:0]] : 8'h00;

  assign push_req  = wr_tx || wr_stop;
  assign push_byte = wr_stop ? 8'h00 : mem_dout;
  assign pop       = tx_valid && tx_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok   = push_req && (!fifo_full || pop);

  always_comb begin
    next_count = tx_count;
    if (push_ok && !pop)
      next_count = tx_count + PTR_ONE;
    else if (!push_ok && pop)
      next_count = tx_count - PTR_ONE;
  end

  always_ff @(posedge clk_in) begin
    if (push_ok)
      fifo_mem[wr_ptr[PTR_W-1:0]] <= push_byte;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tx_overflow    <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push_req && !push_ok)
        tx_overflow <= 1'b1;
      io_buffer_full <= (next_count >= FULL_MARK);
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: read data and TX bytes are queued when
// driven and compared when the DUT presents them.
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = 32'h0;
  logic [7:0]  mem_dout = 8'h0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic        program_stop;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  exp;
  } rd_exp_t;

  rd_exp_t     rd_queue[$];
  logic [7:0]  tx_queue[$];
  int          checks = 0;
  int          errors = 0;
  int          cycles = 0;
  logic [31:0] snap;

  ram_io_responder #(.RAM_ADDR_WIDTH(17), .TX_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .program_stop(program_stop)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle; a queued read expectation is compared once the cycle's edge has passed.
  task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic [7:0] d,
                               input logic chk, input logic [7:0] exp);
    rd_exp_t e;
    mem_a = a;
    mem_wr = wr;
    mem_dout = d;
    if (chk) rd_queue.push_back('{a, exp});
    @(posedge clk_in);
    #1;
    cycles++;
    if (chk) begin
      e = rd_queue.pop_front();
      checkOutput($sformatf("mem_din@%h", e.addr), {24'h0, mem_din}, {24'h0, e.exp});
    end
  endtask

  task automatic idle();
    applyStimulus(32'h00000100, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic pushTxByte(input logic [7:0] d);
    applyStimulus(32'h00030000, 1'b1, d, 1'b0, 8'h00);
    if (d != 8'h00 && tx_queue.size() < 8) tx_queue.push_back(d);
  endtask

  task automatic releaseReset();
    @(negedge clk_in);
    rst_in = 1'b0;
    cycles = 0;
  endtask

  initial begin
    #1 rst_in = 1'b1;
    mem_a = 32'h00030000;
    rx_valid = 1'b1;
    rx_data = 8'h5A;
    #10;
    checkOutput("rst_mem_din", {24'h0, mem_din}, 32'h0);
    checkOutput("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    checkOutput("rst_tx_data", {24'h0, tx_data}, 32'h0);
    checkOutput("rst_rx_pop", {31'h0, rx_pop}, 32'h0);
    checkOutput("rst_program_stop", {31'h0, program_stop}, 32'h0);
    checkOutput("rst_io_buffer_full", {31'h0, io_buffer_full}, 32'h0);
    rx_valid = 1'b0;
    releaseReset();

    // RAM write then read-back, hold-on-write, top address
    applyStimulus(32'h00000010, 1'b1, 8'hA5, 1'b0, 8'h00);
    applyStimulus(32'h00000010, 1'b0, 8'h00, 1'b1, 8'hA5);
    applyStimulus(32'h00000020, 1'b1, 8'h5C, 1'b1, 8'hA5);
    applyStimulus(32'h00000020, 1'b0, 8'h00, 1'b1, 8'h5C);
    applyStimulus(32'h0001FFFF, 1'b1, 8'h77, 1'b0, 8'h00);
    applyStimulus(32'h0001FFFF, 1'b0, 8'h00, 1'b1, 8'h77);

    // Unmapped space must not alias onto RAM
    applyStimulus(32'h00005000, 1'b1, 8'h66, 1'b0, 8'h00);
    applyStimulus(32'h00025000, 1'b0, 8'h00, 1'b1, 8'h00);
    applyStimulus(32'h00025000, 1'b1, 8'h11, 1'b0, 8'h00);
    applyStimulus(32'h00025000, 1'b0, 8'h00, 1'b1, 8'h00);
    applyStimulus(32'h00005000, 1'b0, 8'h00, 1'b1, 8'h66);
    applyStimulus(32'h00030008, 1'b0, 8'h00, 1'b1, 8'h00);

    // UART receive path
    rx_data = 8'h3C; rx_valid = 1'b1;
    mem_a = 32'h00030000; mem_wr = 1'b0; #1;
    checkOutput("rx_pop_valid", {31'h0, rx_pop}, 32'h1);
    applyStimulus(32'h00030000, 1'b0, 8'h00, 1'b1, 8'h3C);
    mem_a = 32'h00000010; #1;
    checkOutput("rx_pop_ram_read", {31'h0, rx_pop}, 32'h0);
    applyStimulus(32'h00000010, 1'b0, 8'h00, 1'b1, 8'hA5);
    rx_valid = 1'b0;
    mem_a = 32'h00030000; #1;
    checkOutput("rx_pop_empty", {31'h0, rx_pop}, 32'h0);
    applyStimulus(32'h00030000, 1'b0, 8'h00, 1'b1, 8'h00);

    // Transmit FIFO fill, threshold, overflow, drain
    tx_ready = 1'b0;
    pushTxByte(8'h41); pushTxByte(8'h00); pushTxByte(8'h42);
    checkOutput("tx_count_2", 32'(dut.tx_count), 32'd2);
    checkOutput("tx_head", {24'h0, tx_data}, 32'h41);
    checkOutput("tx_valid_2", {31'h0, tx_valid}, 32'h1);
    pushTxByte(8'h43); pushTxByte(8'h44); pushTxByte(8'h45);
    checkOutput("full_at_5", {31'h0, io_buffer_full}, 32'h0);
    pushTxByte(8'h46);
    checkOutput("full_at_6", {31'h0, io_buffer_full}, 32'h1);
    pushTxByte(8'h47); pushTxByte(8'h48);
    checkOutput("tx_count_8", 32'(dut.tx_count), 32'd8);
    checkOutput("no_overflow_yet", {31'h0, dut.tx_overflow}, 32'h0);
    pushTxByte(8'h49);
    checkOutput("tx_count_after_drop", 32'(dut.tx_count), 32'd8);
    checkOutput("tx_overflow", {31'h0, dut.tx_overflow}, 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) begin
        if (tx_queue.size() == 0) checkOutput("tx_extra_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
        else checkOutput("tx_drain", {24'h0, tx_data}, {24'h0, tx_queue.pop_front()});
      end
      idle();
    end
    checkOutput("tx_bytes_left", tx_queue.size(), 32'd0);
    checkOutput("tx_valid_drained", {31'h0, tx_valid}, 32'h0);
    checkOutput("full_drained", {31'h0, io_buffer_full}, 32'h0);

    // Cycle counter snapshot after a fresh reset
    #2 rst_in = 1'b1;
    #1;
    releaseReset();
    repeat (100) idle();
    snap = 32'(cycles);
    applyStimulus(32'h00030004, 1'b0, 8'h00, 1'b1, snap[7:0]);
    applyStimulus(32'h00030005, 1'b0, 8'h00, 1'b1, snap[15:8]);
    applyStimulus(32'h00030006, 1'b0, 8'h00, 1'b1, snap[23:16]);
    applyStimulus(32'h00030007, 1'b0, 8'h00, 1'b1, snap[31:24]);
    checkOutput("snapshot_full", dut.snapshot, snap);

    // Program stop, then reset mid-drain
    tx_ready = 1'b0;
    pushTxByte(8'h55);
    applyStimulus(32'h00030004, 1'b1, 8'h99, 1'b0, 8'h00);
    tx_queue.push_back(8'h00);
    checkOutput("program_stop_set", {31'h0, program_stop}, 32'h1);
    checkOutput("tx_count_stop", 32'(dut.tx_count), 32'd2);
    idle(); idle();
    checkOutput("program_stop_sticky", {31'h0, program_stop}, 32'h1);
    tx_ready = 1'b1;
    checkOutput("tx_before_stop", {24'h0, tx_data}, {24'h0, tx_queue.pop_front()});
    applyStimulus(32'h00000010, 1'b0, 8'h00, 1'b1, 8'hA5);
    checkOutput("tx_stop_valid", {31'h0, tx_valid}, 32'h1);
    checkOutput("tx_stop_byte", {24'h0, tx_data}, {24'h0, tx_queue.pop_front()});
    tx_ready = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    checkOutput("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
    checkOutput("midrst_program_stop", {31'h0, program_stop}, 32'h0);
    checkOutput("midrst_mem_din", {24'h0, mem_din}, 32'h0);
    checkOutput("midrst_tx_data", {24'h0, tx_data}, 32'h0);
    releaseReset();
    applyStimulus(32'h00000010, 1'b0, 8'h00, 1'b1, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
